// File: rtl/race_free_sampler_pkg.sv
// race_free_sampler_pkg: shared defaults, drop saturation limit and pointer-width helper
package race_free_sampler_pkg;
  localparam int W_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int TS_W_DEF = 16;
  localparam logic [7:0] DROP_MAX = 8'd255;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/race_free_sampler_if.sv
// race_free_sampler_if: FWFT drain channel (out_valid/out_data/out_ts from master, out_ready from slave)
interface race_free_sampler_if
  import race_free_sampler_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int TS_W = TS_W_DEF
);
  logic out_valid;
  logic out_ready;
  logic [W-1:0] out_data;
  logic [TS_W-1:0] out_ts;
  modport master(output out_valid, out_data, out_ts, input out_ready);
  modport slave(input out_valid, out_data, out_ts, output out_ready);
endinterface

// File: rtl/race_free_sampler_fifo.sv
// race_free_sampler_fifo: FWFT fifo; ports clk rst push pop wdata -> full empty rdata (head)
module race_free_sampler_fifo
  import race_free_sampler_pkg::*;
#(
  parameter int DW = W_DEF + TS_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !rst) mem[wp[AW-1:0]] <= wdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
    end
  end
endmodule

// File: rtl/race_free_sampler.sv
// race_free_sampler: edge-sampled change recorder; clk rst din sample_en -> o (FWFT valid/ready {data,ts}), overflow, drop_count
module race_free_sampler
  import race_free_sampler_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int TS_W = TS_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           din,
  input  logic                   sample_en,
  race_free_sampler_if.master    o,
  output logic                   overflow,
  output logic [7:0]             drop_count
);
  logic [TS_W-1:0] ts;
  logic [W-1:0] prev;
  logic primed, full, empty, hit, push, pop, drop;
  logic [W+TS_W-1:0] head;
  assign hit = sample_en && (!primed || din != prev);
  assign pop = !empty && o.out_ready;
  assign push = hit && (!full || pop);
  assign drop = hit && full && !pop;
  assign o.out_valid = !empty;
  assign o.out_data = head[W+TS_W-1:TS_W];
  assign o.out_ts = head[TS_W-1:0];
  race_free_sampler_fifo #(.DW(W + TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .wdata({din, ts}),
    .full(full),
    .empty(empty),
    .rdata(head)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      ts <= '0;
      prev <= '0;
      primed <= 1'b0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      if (sample_en) begin
        prev <= din;
        primed <= 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        drop_count <= drop_count == DROP_MAX ? DROP_MAX : drop_count + 8'd1;
      end
    end
  end
endmodule
